// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_pkg
// Description : Shared CPU package. Holds the fetch-state encoding, the NOP
//               instruction word and the default reset fetch address.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

    // Fetch control states:
    //   ST_REQ  - request is presented to instruction memory
    //   ST_WAIT - request accepted, waiting for read data
    //   ST_HOLD - instruction buffered and presented to IF/ID
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] c_NOP      = 32'h0000_0000;
    // Word address; byte address 0x3000.
    localparam logic [29:0] c_RESET_PC = 30'h0000_0C00;

endpackage : if_fetch_pkg
`default_nettype wire

// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_if
// Description : Bundle of the fetch stage's control and instruction-memory
//               signals.
//   master (fetch stage) : drives imem_req, imem_addr, if_ins, PC_plus_4,
//                          if_valid; receives hazard, if_flush,
//                          branch_target, id_Jump, jump_target, imem_ready,
//                          imem_rvalid, imem_rdata.
//   slave  (environment) : the opposite directions.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
    logic        hazard;
    logic        if_flush;
    logic [29:0] branch_target;
    logic        id_Jump;
    logic [29:0] jump_target;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_ins;
    logic [29:0] PC_plus_4;
    logic        if_valid;

    modport master (
        input  hazard, if_flush, branch_target, id_Jump, jump_target,
        input  imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, if_ins, PC_plus_4, if_valid
    );

    modport slave (
        output hazard, if_flush, branch_target, id_Jump, jump_target,
        output imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, if_ins, PC_plus_4, if_valid
    );
endinterface : if_fetch_if
`default_nettype wire

// File: rtl/if_fetch_pc_next.sv
`default_nettype none
// ============================================================================
// Module      : pc_next
// Description : Combinational next-PC selection for the fetch stage.
//   pc_i            : current word address
//   branch_target_i : taken-branch word address
//   jump_target_i   : jump word address
//   if_flush_i      : branch redirect (highest priority)
//   id_Jump_i       : jump redirect
//   inc_i           : advance to the sequential address
//   pc_plus1_o      : pc_i + 1 (wraps modulo 2^30)
//   pc_next_o       : selected next pc
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next
    import if_fetch_pkg::*;
(
    input  wire logic [29:0] pc_i,
    input  wire logic [29:0] branch_target_i,
    input  wire logic [29:0] jump_target_i,
    input  wire logic        if_flush_i,
    input  wire logic        id_Jump_i,
    input  wire logic        inc_i,
    output logic      [29:0] pc_plus1_o,
    output logic      [29:0] pc_next_o
);

    // 30-bit add; the carry out is dropped so 30'h3FFF_FFFF wraps to 0.
    assign pc_plus1_o = pc_i + 30'd1;

    // Redirects win over sequential advance in every fetch state.
    always_comb begin
        pc_next_o = pc_i;
        if (if_flush_i) begin
            pc_next_o = branch_target_i;
        end else if (id_Jump_i) begin
            pc_next_o = jump_target_i;
        end else if (inc_i) begin
            pc_next_o = pc_plus1_o;
        end
    end

endmodule : pc_next
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction fetch stage. Issues one instruction-memory
//               request at a time, buffers the returned word and presents it
//               to the IF/ID register until it is consumed or redirected.
//   Clk       : clock, rising edge
//   Rst_n     : asynchronous active-low reset
//   fetch_bus : if_fetch_if.master (hazard/redirect inputs, imem request and
//               response, presented instruction outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [29:0] RESET_PC = c_RESET_PC
) (
    input  wire logic   Clk,
    input  wire logic   Rst_n,
    if_fetch_if.master  fetch_bus
);

    fetch_state_e state_q, state_d;
    logic [29:0]  pc_q, pc_d;
    logic [29:0]  pc_plus1;
    logic [31:0]  ins_buf_q, ins_buf_d;
    logic         drop_q, drop_d;
    logic         redirect;
    logic         consume;

    assign redirect = fetch_bus.if_flush | fetch_bus.id_Jump;
    assign consume  = (state_q == ST_HOLD) && !fetch_bus.hazard;

    pc_next u_pc_next (
        .pc_i            (pc_q),
        .branch_target_i (fetch_bus.branch_target),
        .jump_target_i   (fetch_bus.jump_target),
        .if_flush_i      (fetch_bus.if_flush),
        .id_Jump_i       (fetch_bus.id_Jump),
        .inc_i           (consume),
        .pc_plus1_o      (pc_plus1),
        .pc_next_o       (pc_d)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            ins_buf_q <= c_NOP;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ins_buf_q <= ins_buf_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ins_buf_d = ins_buf_q;
        drop_d    = drop_q;
        case (state_q)
            ST_REQ: begin
                // A redirect in the accept cycle still leaves the old-address
                // request in flight, so its response must be dropped.
                if (fetch_bus.imem_ready) begin
                    state_d = ST_WAIT;
                    drop_d  = redirect;
                end
            end
            ST_WAIT: begin
                if (fetch_bus.imem_rvalid) begin
                    // Response closes the outstanding request; keep it only
                    // if it belongs to the current pc.
                    drop_d = 1'b0;
                    if (drop_q || redirect) begin
                        state_d = ST_REQ;
                    end else begin
                        ins_buf_d = fetch_bus.imem_rdata;
                        state_d   = ST_HOLD;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    ins_buf_d = c_NOP;
                    state_d   = ST_REQ;
                end else if (!fetch_bus.hazard) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
                drop_d  = 1'b0;
            end
        endcase
    end

    assign fetch_bus.imem_req  = (state_q == ST_REQ);
    assign fetch_bus.imem_addr = pc_q;
    assign fetch_bus.if_valid  = (state_q == ST_HOLD);
    assign fetch_bus.if_ins    = (state_q == ST_HOLD) ? ins_buf_q : c_NOP;
    assign fetch_bus.PC_plus_4 = pc_plus1;

endmodule : if_fetch
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch: a directed vector table,
//               a reset-during-WAIT sequence and a randomized run against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(30'h0000_0C00)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .fetch_bus (bus)
    );

    typedef struct {
        logic        hz;
        logic        fl;
        logic [29:0] bt;
        logic        jp;
        logic [29:0] jt;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [29:0] e_addr;
        logic        e_val;
        logic [31:0] e_ins;
        logic [29:0] e_pp4;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: pc, whether a request is in flight, whether its
    // response is stale, and whether an instruction is being presented.
    logic [29:0] m_pc;
    logic        m_out;
    logic        m_disc;
    logic        m_have;
    logic [31:0] m_buf;

    function automatic vec_t mk(input logic hz, input logic fl, input logic [29:0] bt,
                                input logic jp, input logic [29:0] jt,
                                input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic e_req, input logic [29:0] e_addr,
                                input logic e_val, input logic [31:0] e_ins,
                                input logic [29:0] e_pp4);
        vec_t v;
        v.hz = hz; v.fl = fl; v.bt = bt; v.jp = jp; v.jt = jt;
        v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
        v.e_ins = e_ins; v.e_pp4 = e_pp4;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [29:0] e_addr,
                              input logic e_val, input logic [31:0] e_ins,
                              input logic [29:0] e_pp4);
        check({tag, ".imem_req"},  32'(bus.imem_req),  32'(e_req));
        check({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'(e_addr));
        check({tag, ".if_valid"},  32'(bus.if_valid),  32'(e_val));
        check({tag, ".if_ins"},    bus.if_ins,         e_ins);
        check({tag, ".PC_plus_4"}, 32'(bus.PC_plus_4), 32'(e_pp4));
    endtask

    task automatic drive(input logic hz, input logic fl, input logic [29:0] bt,
                         input logic jp, input logic [29:0] jt,
                         input logic rdy, input logic rv, input logic [31:0] rd);
        bus.hazard        = hz;
        bus.if_flush      = fl;
        bus.branch_target = bt;
        bus.id_Jump       = jp;
        bus.jump_target   = jt;
        bus.imem_ready    = rdy;
        bus.imem_rvalid   = rv;
        bus.imem_rdata    = rd;
    endtask

    task automatic model_reset();
        m_pc = 30'h0000_0C00; m_out = 1'b0; m_disc = 1'b0; m_have = 1'b0; m_buf = 32'h0;
    endtask

    task automatic model_step(input logic hz, input logic fl, input logic [29:0] bt,
                              input logic jp, input logic [29:0] jt,
                              input logic rdy, input logic rv, input logic [31:0] rd);
        logic        redir;
        logic [29:0] tgt;
        redir = fl | jp;
        tgt   = fl ? bt : jt;
        if (m_have) begin
            if (redir) begin
                m_have = 1'b0; m_pc = tgt;
            end else if (!hz) begin
                m_have = 1'b0; m_pc = m_pc + 30'd1;
            end
        end else if (!m_out) begin
            if (rdy) begin
                m_out = 1'b1; m_disc = redir;
            end
            if (redir) m_pc = tgt;
        end else begin
            if (rv) begin
                if (!m_disc && !redir) begin
                    m_have = 1'b1; m_buf = rd;
                end
                m_out = 1'b0; m_disc = 1'b0;
            end else if (redir) begin
                m_disc = 1'b1;
            end
            if (redir) m_pc = tgt;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- directed table ----------------
        vq.push_back(mk(0,0,0,0,0, 1,0,32'h0,          0,30'hC00,0,32'h0,30'hC01));
        vq.push_back(mk(0,0,0,0,0, 0,1,32'h2408_0005,  0,30'hC00,1,32'h2408_0005,30'hC01));
        for (int k = 0; k < 4; k++)
            vq.push_back(mk(1,0,0,0,0, 1,0,32'h0,      0,30'hC00,1,32'h2408_0005,30'hC01));
        vq.push_back(mk(0,0,0,0,0, 0,0,32'h0,          1,30'hC01,0,32'h0,30'hC02));
        vq.push_back(mk(0,0,0,0,0, 1,0,32'h0,          0,30'hC01,0,32'h0,30'hC02));
        vq.push_back(mk(0,1,30'hC10,0,0, 0,0,32'h0,    0,30'hC10,0,32'h0,30'hC11));
        vq.push_back(mk(0,0,0,0,0, 0,1,32'hDEAD_BEEF,  1,30'hC10,0,32'h0,30'hC11));
        vq.push_back(mk(0,0,0,0,0, 1,0,32'h0,          0,30'hC10,0,32'h0,30'hC11));
        vq.push_back(mk(0,0,0,0,0, 0,1,32'h1111_1111,  0,30'hC10,1,32'h1111_1111,30'hC11));
        vq.push_back(mk(1,1,30'hC20,1,30'hD00, 0,0,32'h0, 1,30'hC20,0,32'h0,30'hC21));
        vq.push_back(mk(0,0,0,1,30'h3FFF_FFFF, 0,0,32'h0, 1,30'h3FFF_FFFF,0,32'h0,30'h0));
        vq.push_back(mk(0,0,0,0,0, 1,0,32'h0,          0,30'h3FFF_FFFF,0,32'h0,30'h0));
        vq.push_back(mk(0,0,0,0,0, 0,1,32'hAAAA_5555,  0,30'h3FFF_FFFF,1,32'hAAAA_5555,30'h0));
        vq.push_back(mk(0,0,0,0,0, 0,0,32'h0,          1,30'h0,0,32'h0,30'h1));
        vq.push_back(mk(0,1,30'h100,0,0, 1,0,32'h0,    0,30'h100,0,32'h0,30'h101));
        vq.push_back(mk(0,0,0,0,0, 0,1,32'hBAD0_BAD0,  1,30'h100,0,32'h0,30'h101));
        vq.push_back(mk(0,0,0,0,0, 1,0,32'h0,          0,30'h100,0,32'h0,30'h101));
        vq.push_back(mk(0,0,0,1,30'h200, 0,1,32'hCAFE_0000, 1,30'h200,0,32'h0,30'h201));
        vq.push_back(mk(0,0,0,0,0, 1,0,32'h0,          0,30'h200,0,32'h0,30'h201));
        vq.push_back(mk(0,0,0,0,0, 0,1,32'h1234_5678,  0,30'h200,1,32'h1234_5678,30'h201));
        vq.push_back(mk(0,0,0,0,0, 0,1,32'hFFFF_FFFF,  1,30'h201,0,32'h0,30'h202));
        vq.push_back(mk(0,0,0,0,0, 0,1,32'hEEEE_EEEE,  1,30'h201,0,32'h0,30'h202));
        vq.push_back(mk(0,0,0,0,0, 1,0,32'h0,          0,30'h201,0,32'h0,30'h202));
        vq.push_back(mk(0,0,0,0,0, 0,1,32'h0A0B_0C0D,  0,30'h201,1,32'h0A0B_0C0D,30'h202));

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_outs("reset", 1'b1, 30'hC00, 1'b0, 32'h0, 30'hC01);
        Rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].hz, vq[i].fl, vq[i].bt, vq[i].jp, vq[i].jt,
                  vq[i].rdy, vq[i].rv, vq[i].rd);
            @(negedge Clk);
            check_outs($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr,
                       vq[i].e_val, vq[i].e_ins, vq[i].e_pp4);
        end

        // ---------------- reset while waiting for read data ----------------
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        check_outs("rst.pre_req", 1'b1, 30'h202, 1'b0, 32'h0, 30'h203);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge Clk);
        check_outs("rst.wait", 1'b0, 30'h202, 1'b0, 32'h0, 30'h203);
        Rst_n = 1'b0;
        #1;
        check_outs("rst.async", 1'b1, 30'hC00, 1'b0, 32'h0, 30'hC01);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h5555_AAAA);
        @(negedge Clk);
        check_outs("rst.held", 1'b1, 30'hC00, 1'b0, 32'h0, 30'hC01);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_outs("rst.late_rvalid", 1'b1, 30'hC00, 1'b0, 32'h0, 30'hC01);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge Clk);
        check_outs("rst.refetch", 1'b0, 30'hC00, 1'b0, 32'h0, 30'hC01);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h600D_600D);
        @(negedge Clk);
        check_outs("rst.data", 1'b0, 30'hC00, 1'b1, 32'h600D_600D, 30'hC01);

        // ---------------- randomized run against the model ----------------
        Rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        hz, fl, jp, rdy, rv;
            logic [29:0] bt, jt;
            logic [31:0] rd;
            hz  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            jp  = ($urandom_range(0, 7) == 0);
            bt  = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFF : 30'($urandom);
            jt  = 30'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            rd  = $urandom;
            drive(hz, fl, bt, jp, jt, rdy, rv, rd);
            model_step(hz, fl, bt, jp, jt, rdy, rv, rd);
            @(negedge Clk);
            check_outs($sformatf("rand%0d", c), !m_out && !m_have, m_pc, m_have,
                       m_have ? m_buf : 32'h0, m_pc + 30'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_if_fetch
`default_nettype wire
